// File: rtl/booth_q_sequencer_if.sv
// Handshake and datapath bundle between the multiplier
// controller and the radix-4 Booth Q-side sequencer.
interface booth_q_sequencer_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N / 2);

  logic          start;
  logic [N-1:0]  q_in;
  logic          step;
  logic [1:0]    a_shift_in;
  logic [2:0]    triplet;
  logic          booth_zero;
  logic          booth_two;
  logic          booth_neg;
  logic [N-1:0]  q_out;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;

  modport master (
    output start,
    output q_in,
    output step,
    output a_shift_in,
    input  triplet,
    input  booth_zero,
    input  booth_two,
    input  booth_neg,
    input  q_out,
    input  count,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  q_in,
    input  step,
    input  a_shift_in,
    output triplet,
    output booth_zero,
    output booth_two,
    output booth_neg,
    output q_out,
    output count,
    output busy,
    output done
  );
endinterface

// File: rtl/booth_q_sequencer.sv
// Q half of the radix-4 Booth datapath: shifts in the
// accumulator LSBs, recodes the triplet, counts N/2 steps.
module booth_q_sequencer #(
  parameter int N = 8
) (
  input logic clk,
  input logic clr_n,
  booth_q_sequencer_if.slave bus
);
  localparam int CW = $clog2(N / 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic          qm1_q, qm1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          adv;
  logic          last;
  logic [2:0]    trip;

  assign accept = bus.start && (state_q != RUN);
  assign adv    = bus.step && (state_q == RUN);
  assign last   = (cnt_q == CW'(N / 2 - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (bus.step && last) state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
    end
  end

  // start wins over a same-cycle step outside RUN
  always_comb begin
    q_d   = q_q;
    qm1_d = qm1_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      accept: begin
        q_d   = bus.q_in;
        qm1_d = 1'b0;
        cnt_d = '0;
      end
      adv: begin
        q_d   = {bus.a_shift_in, q_q[N-1:2]};
        qm1_d = q_q[1];
        cnt_d = last ? '0 : cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    trip           = {q_q[1:0], qm1_q};
    bus.triplet    = trip;
    bus.booth_zero = (trip == 3'b000) ||
                     (trip == 3'b111);
    bus.booth_two  = (trip == 3'b011) ||
                     (trip == 3'b100);
    bus.booth_neg  = trip[2] && !bus.booth_zero;
    bus.q_out      = q_q;
    bus.count      = cnt_q;
    bus.busy       = (state_q == RUN);
    bus.done       = (state_q == DONE);
  end
endmodule

// File: tb/tb_booth_q_sequencer.sv
// Directed bench for booth_q_sequencer: vector table of
// load/step digits plus reset and handshake sequences.
module tb_booth_q_sequencer;
  localparam int N = 8;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  booth_q_sequencer_if #(.N(N)) bus ();

  booth_q_sequencer #(.N(N)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] qin;
    logic [1:0] a;
    logic [2:0] t0;
    logic [2:0] f0;
    logic [2:0] t1;
    logic [2:0] f1;
    logic [7:0] q1;
  } vec_t;

  vec_t vt [7];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    bus.start = 1'b1;
    bus.q_in  = v;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic dostep(input logic [1:0] a);
    bus.step       = 1'b1;
    bus.a_shift_in = a;
    tick();
    bus.step = 1'b0;
  endtask

  task automatic chk_dig(input string nm,
                         input logic [2:0] t,
                         input logic [2:0] f);
    chk({nm, "_trip"}, 32'(bus.triplet), 32'(t));
    chk({nm, "_zts"},
        32'({bus.booth_zero, bus.booth_two,
             bus.booth_neg}), 32'(f));
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_q"}, 32'(bus.q_out), 32'h0);
    chk({nm, "_cnt"}, 32'(bus.count), 32'h0);
    chk({nm, "_busy"}, 32'(bus.busy), 32'h0);
    chk({nm, "_done"}, 32'(bus.done), 32'h0);
    chk_dig(nm, 3'b000, 3'b100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'h03, 2'b00, 3'b110, 3'b001,
              3'b001, 3'b000, 8'h00};
    vt[1] = '{8'h06, 2'b00, 3'b100, 3'b011,
              3'b011, 3'b010, 8'h01};
    vt[2] = '{8'h0A, 2'b00, 3'b100, 3'b011,
              3'b101, 3'b001, 8'h02};
    vt[3] = '{8'hFF, 2'b11, 3'b110, 3'b001,
              3'b111, 3'b100, 8'hFF};
    vt[4] = '{8'h01, 2'b00, 3'b010, 3'b000,
              3'b000, 3'b100, 8'h00};
    vt[5] = '{8'h00, 2'b10, 3'b000, 3'b100,
              3'b000, 3'b100, 8'h80};
    vt[6] = '{8'h5A, 2'b01, 3'b100, 3'b011,
              3'b101, 3'b001, 8'h56};

    bus.start      = 1'b0;
    bus.step       = 1'b0;
    bus.q_in       = '0;
    bus.a_shift_in = '0;
    #12 clr_n = 1'b1;

    // step in IDLE must be dropped
    tick();
    dostep(2'b11);
    chk_rst("idle_step");

    // async reset mid-cycle, no clock edge
    load(8'hFF);
    chk("pre_rst_q", 32'(bus.q_out), 32'hFF);
    #2 clr_n = 1'b0;
    #1;
    chk_rst("async_rst");
    #2 clr_n = 1'b1;
    tick();

    load(8'h03);
    chk("ld03_busy", 32'(bus.busy), 32'h1);
    chk_dig("ld03", 3'b110, 3'b001);

    // start during RUN is ignored
    load(8'hFF);
    chk("run_start_q", 32'(bus.q_out), 32'h03);
    chk("run_start_cnt", 32'(bus.count), 32'h0);
    for (int i = 0; i < 3; i++) dostep(2'b00);
    chk("pre_done_cnt", 32'(bus.count), 32'h3);
    chk("pre_done_done", 32'(bus.done), 32'h0);
    dostep(2'b00);
    chk("d1_done", 32'(bus.done), 32'h1);

    // load 00, shift in 10 four times
    load(8'h00);
    for (int i = 0; i < 4; i++) dostep(2'b10);
    chk("aa_q", 32'(bus.q_out), 32'hAA);
    chk("aa_done", 32'(bus.done), 32'h1);
    chk("aa_busy", 32'(bus.busy), 32'h0);
    chk("aa_cnt", 32'(bus.count), 32'h0);
    dostep(2'b11);
    tick();
    chk("aa_hold_q", 32'(bus.q_out), 32'hAA);
    chk("aa_hold_done", 32'(bus.done), 32'h1);

    for (int k = 0; k < 7; k++) begin
      load(vt[k].qin);
      chk_dig($sformatf("v%0d_ld", k),
              vt[k].t0, vt[k].f0);
      dostep(vt[k].a);
      chk_dig($sformatf("v%0d_st", k),
              vt[k].t1, vt[k].f1);
      chk($sformatf("v%0d_q", k),
          32'(bus.q_out), 32'(vt[k].q1));
      chk($sformatf("v%0d_cnt", k),
          32'(bus.count), 32'h1);
      for (int i = 0; i < 3; i++) dostep(2'b00);
      chk($sformatf("v%0d_done", k),
          32'(bus.done), 32'h1);
    end

    // start + step together in DONE: load only
    bus.step       = 1'b1;
    bus.a_shift_in = 2'b11;
    load(8'h33);
    bus.step = 1'b0;
    chk("ss_q", 32'(bus.q_out), 32'h33);
    chk("ss_cnt", 32'(bus.count), 32'h0);
    chk("ss_busy", 32'(bus.busy), 32'h1);
    chk_dig("ss", 3'b110, 3'b001);
    for (int i = 0; i < 4; i++) dostep(2'b00);

    // reset two steps into an operation
    load(8'h5A);
    dostep(2'b01);
    dostep(2'b01);
    chk("mid_cnt", 32'(bus.count), 32'h2);
    #2 clr_n = 1'b0;
    #1;
    chk_rst("mid_rst");
    #2 clr_n = 1'b1;
    tick();
    chk_rst("post_rst");
    load(8'hC3);
    chk("rl_q", 32'(bus.q_out), 32'hC3);
    chk("rl_busy", 32'(bus.busy), 32'h1);
    chk("rl_cnt", 32'(bus.count), 32'h0);
    chk_dig("rl", 3'b110, 3'b001);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
